// File: rtl/osc_sequencer_if.sv
// rtl/osc_sequencer_if.sv - note table write port shared by the controller and osc_sequencer
interface osc_sequencer_if #(
    parameter int DEPTH     = 16,
    parameter int LEN_WIDTH = 16
);
    logic                     wr_en;
    logic [$clog2(DEPTH)-1:0] wr_addr;
    logic [31:0]              wr_divisor;
    logic [7:0]               wr_duty;
    logic                     wr_waveform;
    logic [LEN_WIDTH-1:0]     wr_length;

    modport master (
        output wr_en, wr_addr, wr_divisor, wr_duty, wr_waveform, wr_length
    );

    modport slave (
        input wr_en, wr_addr, wr_divisor, wr_duty, wr_waveform, wr_length
    );
endinterface

// File: rtl/osc_sequencer.sv
// rtl/osc_sequencer.sv - note table step sequencer driving one audio_oscillator voice
// Optional portamento build: define OSC_SEQ_GLIDE_EN.
module osc_sequencer #(
    parameter int DEPTH       = 16,
    parameter int LEN_WIDTH   = 16,
    parameter int GAP_SAMPLES = 0,
    parameter int GLIDE_SHIFT = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    osc_sequencer_if.slave           wr,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic [$clog2(DEPTH)-1:0] last_index,
    input  logic                     sample_tick,
    output logic [31:0]              divisor,
    output logic [7:0]               duty,
    output logic                     waveform,
    output logic                     gate,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] step_index,
    output logic                     done
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GAP_SAMPLES > 1) ? $clog2(GAP_SAMPLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_SAMPLES > 0) ? GAP_SAMPLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_t;

    logic [31:0]          tbl_divisor [DEPTH];
    logic [7:0]           tbl_duty    [DEPTH];
    logic                 tbl_waveform[DEPTH];
    logic [LEN_WIDTH-1:0] tbl_length  [DEPTH];

    state_t               state_q,    state_d;
    logic [AW-1:0]        step_q,     step_d;
    logic [31:0]          divisor_q,  divisor_d;
    logic [7:0]           duty_q,     duty_d;
    logic                 wave_q,     wave_d;
    logic                 gate_q,     gate_d;
    logic                 done_q,     done_d;
    logic [LEN_WIDTH-1:0] cnt_q,      cnt_d;
    logic [LEN_WIDTH-1:0] len_q,      len_d;
    logic [GW-1:0]        gap_cnt_q,  gap_cnt_d;
    logic                 advance;
    logic                 seq_end;
    logic                 unused_ok;

`ifdef OSC_SEQ_GLIDE_EN
    logic [31:0]          target_q,   target_d;
    logic signed [32:0]   glide_diff;
    logic signed [32:0]   glide_step;
    logic signed [32:0]   glide_sum;
    logic [31:0]          glide_next;

    always_comb begin
        glide_diff = $signed({1'b0, target_q}) - $signed({1'b0, divisor_q});
        glide_step = glide_diff >>> GLIDE_SHIFT;
        // Shift rounds small differences to zero; force a unit step so the glide always lands.
        if (glide_step == 33'sd0 && glide_diff != 33'sd0) begin
            glide_step = glide_diff[32] ? -33'sd1 : 33'sd1;
        end
        glide_sum  = $signed({1'b0, divisor_q}) + glide_step;
        glide_next = glide_sum[31:0];
    end

    assign unused_ok = glide_sum[32];
`else
    assign unused_ok = ^GLIDE_SHIFT;
`endif

    // Table has no reset; entries are only meaningful once written.
    always_ff @(posedge clk) begin
        if (wr.wr_en) begin
            tbl_divisor[wr.wr_addr]  <= wr.wr_divisor;
            tbl_duty[wr.wr_addr]     <= wr.wr_duty;
            tbl_waveform[wr.wr_addr] <= wr.wr_waveform;
            tbl_length[wr.wr_addr]   <= wr.wr_length;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            divisor_q <= '0;
            duty_q    <= '0;
            wave_q    <= 1'b0;
            gate_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            len_q     <= '0;
            gap_cnt_q <= '0;
`ifdef OSC_SEQ_GLIDE_EN
            target_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            divisor_q <= divisor_d;
            duty_q    <= duty_d;
            wave_q    <= wave_d;
            gate_q    <= gate_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            gap_cnt_q <= gap_cnt_d;
`ifdef OSC_SEQ_GLIDE_EN
            target_q  <= target_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        divisor_d = divisor_q;
        duty_d    = duty_q;
        wave_d    = wave_q;
        gate_d    = gate_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        len_d     = len_q;
        gap_cnt_d = gap_cnt_q;
        advance   = 1'b0;
        seq_end   = 1'b0;
`ifdef OSC_SEQ_GLIDE_EN
        target_d  = target_q;
`endif

        case (state_q)
            S_IDLE: begin
                divisor_d = '0;
                gate_d    = 1'b0;
                if (start) begin
                    state_d = S_LOAD;
                    step_d  = '0;
                end
            end

            S_LOAD: begin
                if (tbl_length[step_q] == '0) begin
                    seq_end = 1'b1;
                end else begin
`ifdef OSC_SEQ_GLIDE_EN
                    target_d  = tbl_divisor[step_q];
                    // From silence there is nothing to glide from, so start on pitch.
                    divisor_d = (divisor_q == '0) ? tbl_divisor[step_q] : divisor_q;
`else
                    divisor_d = tbl_divisor[step_q];
`endif
                    duty_d    = tbl_duty[step_q];
                    wave_d    = tbl_waveform[step_q];
                    len_d     = tbl_length[step_q];
                    gate_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_PLAY;
                end
            end

            S_PLAY: begin
                if (sample_tick) begin
`ifdef OSC_SEQ_GLIDE_EN
                    divisor_d = glide_next;
`endif
                    if (cnt_q == len_q - LEN_WIDTH'(1)) begin
                        gate_d = 1'b0;
`ifndef OSC_SEQ_GLIDE_EN
                        divisor_d = '0;
`endif
                        if (GAP_SAMPLES > 0) begin
                            state_d   = S_GAP;
                            gap_cnt_d = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + LEN_WIDTH'(1);
                    end
                end
            end

            S_GAP: begin
                if (sample_tick) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        advance = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GW'(1);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // last_index and loop_en are deliberately sampled here, at each advance.
        if (advance) begin
            if (step_q == last_index) begin
                seq_end = 1'b1;
            end else begin
                step_d  = step_q + AW'(1);
                state_d = S_LOAD;
            end
        end

        if (seq_end) begin
            if (loop_en) begin
                step_d  = '0;
                state_d = S_LOAD;
            end else begin
                done_d    = 1'b1;
                state_d   = S_IDLE;
                divisor_d = '0;
                gate_d    = 1'b0;
            end
        end

        if (stop) begin
            state_d   = S_IDLE;
            divisor_d = '0;
            gate_d    = 1'b0;
            done_d    = 1'b0;
        end
    end

    assign divisor    = divisor_q;
    assign duty       = duty_q;
    assign waveform   = wave_q;
    assign gate       = gate_q;
    assign busy       = (state_q != S_IDLE);
    assign step_index = step_q;
    assign done       = done_q;
endmodule
